// File: rtl/bc_if_pkg.sv
// Shared types and helpers for the prefetching instruction-fetch stage.
package bc_if_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 32;
  localparam int unsigned INSTR_BYTES     = INSTR_WIDTH_DEF / 8;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0]  pc;
    logic [INSTR_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

  // Clears the low lsb bits of an address (up to 64-bit addresses).
  function automatic logic [63:0] pc_align(input logic [63:0] addr, input int unsigned lsb);
    logic [63:0] mask;
    mask = ~((64'd1 << lsb) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/bc_stage_if_prefetch_fifo.sv
// Generic show-ahead FIFO: head entry is visible combinationally while not empty.
module bc_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  assign rdata_o  = mem[rd_ptr_q];
  assign pop_eff  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_eff && !flush_i) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bc_stage_if_prefetch.sv
// Instruction fetch stage with multiple reads in flight and a prefetch queue toward decode.
module bc_stage_if_prefetch
  import bc_if_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          INSTR_WIDTH     = 32,
  parameter int unsigned          FIFO_DEPTH      = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  output logic [ADDR_WIDTH-1:0]  o_imem_raddr,
  output logic                   o_imem_raddr_valid,
  input  logic                   i_imem_raddr_ready,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  input  logic                   i_imem_rdata_valid,
  output logic                   o_imem_rdata_ready,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc
);

  localparam int unsigned BYTES = INSTR_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW    = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(BYTES);
  localparam logic [63:0]           MASK64     = pc_align('1, LSB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = MASK64[ADDR_WIDTH-1:0];

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic [OW-1:0]         drop_cnt_q, drop_cnt_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_wdata, fifo_rdata;

  logic credit_ok, issue_valid, issue_fire, rsp_fire;

  // Every in-flight read owns a queue slot, so responses never need back-pressure.
  assign credit_ok   = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                       ((32'(outstanding_q) + 32'(fifo_count)) < FIFO_DEPTH) &&
                       !fifo_full;
  assign issue_valid = i_rstn && !i_redirect && credit_ok;
  assign issue_fire  = issue_valid && i_imem_raddr_ready;
  assign rsp_fire    = i_imem_rdata_valid;

  assign fifo_push  = rsp_fire && (drop_cnt_q == '0) && !i_redirect;
  assign fifo_pop   = !fifo_empty && i_instr_ready;
  assign fifo_wdata = {resp_pc_q, i_imem_rdata};

  assign o_imem_raddr       = fetch_pc_q;
  assign o_imem_raddr_valid = issue_valid;
  assign o_imem_rdata_ready = 1'b1;
  assign o_instr_valid      = !fifo_empty;
  assign {o_pc, o_instr}    = fifo_rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (i_redirect) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc_d    = i_redirect_pc & ALIGN_MASK;
      resp_pc_d     = i_redirect_pc & ALIGN_MASK;
      outstanding_d = outstanding_q - OW'(rsp_fire);
      drop_cnt_d    = outstanding_q - OW'(rsp_fire);
    end else begin
      if (issue_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_fire) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OW'(1);
        else                  resp_pc_d  = resp_pc_q + PC_STEP;
      end
      outstanding_d = outstanding_q + OW'(issue_fire) - OW'(rsp_fire);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  bc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (i_redirect),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_bc_stage_if_prefetch.sv
// Randomized bench for bc_stage_if_prefetch against a queue-based fetch/decode stream model.
module tb_bc_stage_if_prefetch;

  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic          i_clk;
  logic          i_rstn;
  logic [AW-1:0] o_imem_raddr;
  logic          o_imem_raddr_valid;
  logic          i_imem_raddr_ready;
  logic [IW-1:0] i_imem_rdata;
  logic          i_imem_rdata_valid;
  logic          o_imem_rdata_ready;
  logic          i_redirect;
  logic [AW-1:0] i_redirect_pc;
  logic          o_instr_valid;
  logic          i_instr_ready;
  logic [IW-1:0] o_instr;
  logic [AW-1:0] o_pc;

  bc_stage_if_prefetch #(
    .ADDR_WIDTH      (AW),
    .INSTR_WIDTH     (IW),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .o_imem_raddr       (o_imem_raddr),
    .o_imem_raddr_valid (o_imem_raddr_valid),
    .i_imem_raddr_ready (i_imem_raddr_ready),
    .i_imem_rdata       (i_imem_rdata),
    .i_imem_rdata_valid (i_imem_rdata_valid),
    .o_imem_rdata_ready (o_imem_rdata_ready),
    .i_redirect         (i_redirect),
    .i_redirect_pc      (i_redirect_pc),
    .o_instr_valid      (o_instr_valid),
    .i_instr_ready      (i_instr_ready),
    .o_instr            (o_instr),
    .o_pc               (o_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  // Memory model and spec-level fetch model.
  req_t        mq[$];
  logic [63:0] m_q[$];
  logic [31:0] m_fetch, m_resp, stream_pc;
  int          m_outs, m_drop;
  int          cyc, lat, dec_mode, issue_cnt;
  bit          mem_rand, redir_req;
  logic [31:0] redir_pc;
  bit          got_issue, got_pop;
  logic [31:0] first_issue, first_pop;

  task automatic model_reset();
    mq.delete();
    m_q.delete();
    m_fetch   = RPC;
    m_resp    = RPC;
    stream_pc = RPC;
    m_outs    = 0;
    m_drop    = 0;
    issue_cnt = 0;
    got_issue = 0;
    got_pop   = 0;
    redir_req = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rstn             = 1'b0;
    i_redirect         = 1'b0;
    i_imem_rdata_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_ivalid", 64'(o_instr_valid), 64'd0);
    chk("rst_rvalid", 64'(o_imem_raddr_valid), 64'd0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
  endtask

  task automatic step();
    bit exp_rv, rsp, iss, pop;
    @(negedge i_clk);
    i_imem_raddr_ready = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    case (dec_mode)
      0:       i_instr_ready = 1'b1;
      1:       i_instr_ready = 1'b0;
      default: i_instr_ready = 1'($urandom_range(0, 1));
    endcase
    i_redirect    = redir_req;
    i_redirect_pc = redir_pc;
    redir_req     = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_imem_rdata_valid = 1'b1;
      i_imem_rdata       = memf(mq[0].addr);
    end else begin
      i_imem_rdata_valid = 1'b0;
      i_imem_rdata       = $urandom;
    end
    #1;
    exp_rv = !i_redirect && (m_outs < int'(MAXO)) && (m_outs + m_q.size() < int'(DEPTH));
    chk("raddr_valid", 64'(o_imem_raddr_valid), 64'(exp_rv));
    if (exp_rv) chk("raddr", 64'(o_imem_raddr), 64'(m_fetch));
    chk("rdata_ready", 64'(o_imem_rdata_ready), 64'd1);
    chk("instr_valid", 64'(o_instr_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("head", {o_pc, o_instr}, m_q[0]);
    chk("outstanding", 64'(dut.outstanding_q), 64'(m_outs));
    chk("a_outs_max", 64'(dut.outstanding_q <= MAXO), 64'd1);
    chk("a_drop_le", 64'(dut.drop_cnt_q <= dut.outstanding_q), 64'd1);
    chk("a_push_full", 64'(dut.fifo_push && dut.fifo_full && !dut.fifo_pop), 64'd0);

    rsp = i_imem_rdata_valid;
    iss = exp_rv && i_imem_raddr_ready;
    pop = (m_q.size() > 0) && i_instr_ready;
    if (rsp) chk("a_rsp_outs", 64'(dut.outstanding_q != 0), 64'd1);

    // Decode-side view: accepted instructions form a contiguous stream.
    if (pop && !i_redirect) begin
      chk("stream_pc", 64'(o_pc), 64'(stream_pc));
      chk("stream_instr", 64'(o_instr), 64'(memf(stream_pc)));
      if (!got_pop) begin
        got_pop   = 1;
        first_pop = o_pc;
      end
      stream_pc = stream_pc + 32'd4;
    end

    if (rsp) void'(mq.pop_front());
    if (o_imem_raddr_valid && i_imem_raddr_ready) begin
      mq.push_back('{addr: o_imem_raddr, due: cyc + lat});
      issue_cnt++;
      if (!got_issue) begin
        got_issue   = 1;
        first_issue = o_imem_raddr;
      end
    end

    if (i_redirect) begin
      m_q.delete();
      m_outs    = m_outs - int'(rsp);
      m_drop    = m_outs;
      m_fetch   = i_redirect_pc & ~32'h3;
      m_resp    = m_fetch;
      stream_pc = m_fetch;
      got_issue = 0;
      got_pop   = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else begin
          m_q.push_back({m_resp, memf(m_resp)});
          m_resp = m_resp + 32'd4;
        end
      end
      if (iss) m_fetch = m_fetch + 32'd4;
      m_outs = m_outs + int'(iss) - int'(rsp);
    end
    cyc++;
  endtask

  initial begin
    int k;
    i_rstn             = 1'b0;
    i_imem_raddr_ready = 1'b0;
    i_imem_rdata       = '0;
    i_imem_rdata_valid = 1'b0;
    i_redirect         = 1'b0;
    i_redirect_pc      = '0;
    i_instr_ready      = 1'b0;
    cyc = 0; lat = 1; dec_mode = 0; mem_rand = 0; redir_pc = '0;
    model_reset();

    // Streaming, zero-wait memory.
    do_reset();
    repeat (30) step();
    chk("stream_first_issue", 64'(first_issue), 64'(RPC));
    chk("stream_first_pop", 64'(first_pop), 64'(RPC));

    // Decode stall: issue must stop after DEPTH requests.
    do_reset();
    dec_mode = 1;
    repeat (20) step();
    chk("stall_issues", 64'(issue_cnt), 64'(DEPTH));
    dec_mode = 0;
    repeat (20) step();
    chk("stall_first_pop", 64'(first_pop), 64'(RPC));

    // Redirect while 0x10 and 0x14 are in flight.
    do_reset();
    lat = 3;
    k = 0;
    while (!(m_outs == 2 && m_fetch == 32'h18) && k < 100) begin
      step();
      k++;
    end
    chk("wait_inflight", 64'(m_outs == 2 && m_fetch == 32'h18), 64'd1);
    redir_req = 1; redir_pc = 32'h100;
    step();
    repeat (20) step();
    chk("redir_first_pop", 64'(first_pop), 64'h100);

    // Unaligned redirect coinciding with a response.
    do_reset();
    lat = 1;
    repeat (8) step();
    chk("coinc_rsp_due", 64'(mq.size() > 0 && mq[0].due <= cyc), 64'd1);
    redir_req = 1; redir_pc = 32'h203;
    step();
    repeat (10) step();
    chk("align_first_issue", 64'(first_issue), 64'h200);
    chk("align_first_pop", 64'(first_pop), 64'h200);

    // Back-pressured memory with latency 3, random decode ready, random redirects.
    do_reset();
    lat = 3; mem_rand = 1; dec_mode = 2;
    repeat (300) step();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        redir_req = 1;
        redir_pc  = $urandom;
      end
      step();
    end
    lat = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        redir_req = 1;
        redir_pc  = $urandom;
      end
      step();
    end

    // Async reset with three entries queued.
    do_reset();
    lat = 1; mem_rand = 0; dec_mode = 1;
    k = 0;
    while (m_q.size() != 3 && k < 50) begin
      step();
      k++;
    end
    chk("wait_three", 64'(m_q.size()), 64'd3);
    chk("pre_rst_ivalid", 64'(o_instr_valid), 64'd1);
    @(posedge i_clk);
    #2 i_rstn = 1'b0;
    #1;
    chk("async_ivalid", 64'(o_instr_valid), 64'd0);
    chk("async_rvalid", 64'(o_imem_raddr_valid), 64'd0);
    i_imem_rdata_valid = 1'b0;
    i_redirect         = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    dec_mode = 0;
    repeat (20) step();
    chk("restart_issue", 64'(first_issue), 64'(RPC));
    chk("restart_pop", 64'(first_pop), 64'(RPC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
